packet_demux_1_to_n: RTL
========================

// Module: packet_demux_1_to_n
// PURPOSE
//  Packet-locked 1-to-NUM_OUT AXI-stream demultiplexer; successor to the tree arbitrator's 1-to-n fan-out.
//  Destination is sampled from ctl on the SOP beat and held for the whole packet, so ctl changes mid-packet cannot split it.
//  Each output has a registered 2-entry skid buffer, so fan-out timing is cut without losing throughput.
//  Packets whose destination index is >= NUM_OUT are consumed and dropped and counted, never forwarded.
// PARAMETERS
//  DAT_BYTS      8                      data bytes per beat
//  DAT_BITS      DAT_BYTS*8             data width
//  CTL_BITS      8                      ctl sideband width
//  NUM_OUT       8                      output channels, >=1, need not be a power of 2
//  LOG2_NUM_OUT  max(1,$clog2(NUM_OUT)) width of destination field
//  OVR_WRT_BIT   CTL_BITS-LOG2_NUM_OUT  LSB of destination field in ctl
//  CNT_BITS      16                     width of drop counter, saturating
// PORTS
//  i_clk        in   1            clock
//  i_rst        in   1            asynchronous, active-high reset
//  i_axi        sink if_axi_stream (DAT_BITS, CTL_BITS) input packet stream
//  o_n_axi      src  if_axi_stream [NUM_OUT-1:0] per-channel outputs; ctl passed unmodified
//  o_drop_cnt   out  CNT_BITS     packets dropped for out-of-range destination
//  o_busy       out  1            1 while a packet is mid-flight (state != IDLE)
// BEHAVIOUR
//  Reset: state=IDLE, dest_q=0, all skid entries invalid (o_n_axi[*].val=0), o_drop_cnt=0, o_busy=0.
//  Reset takes effect immediately, including mid-packet. The partial packet is lost. No EOP is emitted for it.
//  dest = i_axi.ctl[OVR_WRT_BIT +: LOG2_NUM_OUT]. It is evaluated only on an accepted SOP beat.
//  FSM states: IDLE, FWD, DROP.
//   IDLE: i_axi.rdy = (dest<NUM_OUT) ? skid[dest].in_rdy : 1. Whether rdy is asserted does not depend on val.
//         Accepted SOP&&!EOP: go to FWD (dest_q=dest) if dest in range, else go to DROP.
//         Accepted SOP&&EOP: stay in IDLE. The beat is forwarded, or dropped and counted.
//         Accepted beat without SOP: discard it silently and stay in IDLE (protocol error, not counted).
//   FWD:  routing uses dest_q; ctl is ignored. i_axi.rdy = skid[dest_q].in_rdy. Accepted EOP -> IDLE.
//         A SOP seen in FWD is treated as data, with no re-route.
//   DROP: i_axi.rdy=1. Accepted beats are discarded. Accepted EOP -> IDLE.
//  Drop counter: increments once per dropped packet, on its SOP beat. It saturates at all-ones.
//  Skid buffer per channel: 2 entries, registered outputs.
//   Latency input->output is 1 cycle.
//   in_rdy=1 while at least one entry is free, so full throughput is sustained with no bubbles.
//   in_rdy is registered and does not depend combinationally on o_n_axi[*].rdy.
//   Beat order is preserved. dat/sop/eop/err/mod/ctl are carried unchanged.
//  Only one channel receives a beat per cycle. Other channels keep draining independently.
//   A stalled channel never blocks data already buffered for other channels.
//   It blocks the input only while the input is routed to it.
//  Simultaneous EOP accept and next-cycle SOP: a back-to-back packet to a different channel is accepted with no idle cycle.
// STRUCTURE
//  packet_demux_pkg: typedef enum logic [1:0] {IDLE,FWD,DROP} demux_state_t; function dest_in_range().
//  Sub-module packet_demux_skid: 2-entry AXI-stream skid buffer (if_axi_stream sink/source, i_clk, i_rst).
//   It is instanced NUM_OUT times in a generate loop.
//  Top level: FSM, dest_q, drop counter, input rdy mux, per-channel val steering.
// TESTING
//  1. NUM_OUT=8. 3-beat packet, ctl dest=5 on SOP, dest field changed to 2 on beats 2-3.
//     -> all 3 beats appear on ch5 only, 1 cycle later; ch2 sees nothing.
//  2. Back-to-back single-beat packets (SOP&EOP) to dest 0,1,2,3 with all rdy=1.
//     -> one beat per cycle, each on its channel; i_axi.rdy stays 1 throughout.
//  3. ch4 rdy=0, 4-beat packet to ch4.
//     -> i_axi.rdy drops after 2 beats are buffered.
//     -> raising ch4 rdy delivers all 4 beats in order; ch1 traffic already buffered drains meanwhile.
//  4. NUM_OUT=6, 3-beat packet with dest=7.
//     -> no output val on any channel; i_axi.rdy=1 for all beats; o_drop_cnt 0->1; next packet to dest 1 is routed normally.
//  5. Assert i_rst on beat 2 of a 4-beat packet to ch3.
//     -> all val=0, o_busy=0, o_drop_cnt=0 immediately.
//     -> after release, a new SOP to ch0 routes correctly; leftover non-SOP beats are discarded.
//  6. Drive 2^CNT_BITS+3 dropped packets (CNT_BITS=4).
//     -> o_drop_cnt saturates at 15 and holds.

Source files
------------

// File: rtl/packet_demux_pkg.sv
// Shared types and helpers for the packet-locked 1-to-N stream demultiplexer.
package packet_demux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } demux_state_t;

  function automatic logic dest_in_range(input int unsigned dest, input int unsigned num_out);
    return dest < num_out;
  endfunction

endpackage

// File: rtl/packet_demux_if.sv
// AXI-stream style bus: val/rdy handshake with sop/eop framing, err, byte-valid mod and ctl sideband.
interface if_axi_stream #(
  parameter int DAT_BITS = 64,
  parameter int CTL_BITS = 8,
  parameter int MOD_BITS = ((DAT_BITS / 8) > 1) ? $clog2(DAT_BITS / 8) : 1
);
  logic                val;
  logic                rdy;
  logic                sop;
  logic                eop;
  logic                err;
  logic [MOD_BITS-1:0] mod;
  logic [DAT_BITS-1:0] dat;
  logic [CTL_BITS-1:0] ctl;

  modport master (output val, sop, eop, err, mod, dat, ctl, input rdy);
  modport slave  (input val, sop, eop, err, mod, dat, ctl, output rdy);
endinterface

// File: rtl/packet_demux_skid.sv
// Two-entry skid buffer: registered output stage plus one overflow entry; in_rdy comes straight from a flop.
module packet_demux_skid #(
  parameter int DAT_BITS = 64,
  parameter int CTL_BITS = 8,
  parameter int MOD_BITS = 3
) (
  input  logic          i_clk,
  input  logic          i_rst,
  if_axi_stream.slave   i_axi,
  if_axi_stream.master  o_axi
);

  localparam int W = DAT_BITS + CTL_BITS + MOD_BITS + 3;

  logic [W-1:0] w_in_bus;
  logic [W-1:0] r_out_bus;
  logic [W-1:0] r_skid_bus;
  logic         r_out_val;
  logic         r_in_rdy;
  logic         w_in_acc;

  assign w_in_bus  = {i_axi.dat, i_axi.ctl, i_axi.mod, i_axi.err, i_axi.eop, i_axi.sop};
  assign w_in_acc  = i_axi.val && r_in_rdy;
  assign i_axi.rdy = r_in_rdy;

  // r_in_rdy low means the overflow entry holds a beat behind the output stage
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_val <= 1'b0;
      r_in_rdy  <= 1'b1;
    end else if (r_in_rdy) begin
      if (w_in_acc && r_out_val && !o_axi.rdy) r_in_rdy  <= 1'b0;
      else if (w_in_acc)                       r_out_val <= 1'b1;
      else if (o_axi.rdy)                      r_out_val <= 1'b0;
    end else if (o_axi.rdy) begin
      r_in_rdy <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (r_in_rdy) begin
      if (w_in_acc && (!r_out_val || o_axi.rdy)) r_out_bus  <= w_in_bus;
      else if (w_in_acc)                         r_skid_bus <= w_in_bus;
    end else if (o_axi.rdy) begin
      r_out_bus <= r_skid_bus;
    end
  end

  assign o_axi.val = r_out_val;
  assign {o_axi.dat, o_axi.ctl, o_axi.mod, o_axi.err, o_axi.eop, o_axi.sop} = r_out_bus;

endmodule

// File: rtl/packet_demux_1_to_n.sv
// Packet-locked 1-to-NUM_OUT demultiplexer: destination latched on SOP, out-of-range packets dropped and counted.
module packet_demux_1_to_n
  import packet_demux_pkg::*;
#(
  parameter int DAT_BYTS     = 8,
  parameter int DAT_BITS     = DAT_BYTS * 8,
  parameter int CTL_BITS     = 8,
  parameter int NUM_OUT      = 8,
  parameter int LOG2_NUM_OUT = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1,
  parameter int OVR_WRT_BIT  = CTL_BITS - LOG2_NUM_OUT,
  parameter int CNT_BITS     = 16,
  parameter int MOD_BITS     = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  if_axi_stream.slave         i_axi,
  if_axi_stream.master        o_n_axi [NUM_OUT-1:0],
  output logic [CNT_BITS-1:0] o_drop_cnt,
  output logic                o_busy
);

  // Selector space is padded to a power of two; padded slots read as ready
  localparam int SEL_N = 1 << LOG2_NUM_OUT;

  demux_state_t              r_state;
  demux_state_t              w_state_nxt;
  logic [LOG2_NUM_OUT-1:0]   w_dest;
  logic [LOG2_NUM_OUT-1:0]   r_dest_q;
  logic [LOG2_NUM_OUT-1:0]   w_sel;
  logic                      w_dest_ok;
  logic                      w_rdy;
  logic                      w_route;
  logic                      w_load_dest;
  logic                      w_drop_pkt;
  logic [SEL_N-1:0]          w_ch_rdy;
  logic [CNT_BITS-1:0]       r_drop_cnt;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_dest    = i_axi.ctl[OVR_WRT_BIT +: LOG2_NUM_OUT];
  assign w_dest_ok = dest_in_range(32'(w_dest), 32'(NUM_OUT));
  assign i_axi.rdy = w_rdy;

  always_comb begin
    w_state_nxt = r_state;
    w_sel       = r_dest_q;
    w_rdy       = 1'b1;
    w_route     = 1'b0;
    w_load_dest = 1'b0;
    w_drop_pkt  = 1'b0;
    case (r_state)
      IDLE: begin
        w_sel = w_dest;
        w_rdy = w_dest_ok ? w_ch_rdy[w_dest] : 1'b1;
        if (i_axi.val && w_rdy && i_axi.sop) begin
          w_route     = w_dest_ok;
          w_load_dest = w_dest_ok;
          w_drop_pkt  = !w_dest_ok;
          if (!i_axi.eop) w_state_nxt = w_dest_ok ? FWD : DROP;
        end
      end
      FWD: begin
        w_rdy   = w_ch_rdy[r_dest_q];
        w_route = i_axi.val && w_rdy;
        if (i_axi.val && w_rdy && i_axi.eop) w_state_nxt = IDLE;
      end
      DROP: begin
        if (i_axi.val && i_axi.eop) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_dest_q   <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_dest) r_dest_q   <= w_dest;
      if (w_drop_pkt)  r_drop_cnt <= sat_inc(r_drop_cnt);
    end
  end

  assign o_drop_cnt = r_drop_cnt;
  assign o_busy     = (r_state != IDLE);

  for (genvar g = 0; g < SEL_N; g++) begin : g_ch
    if (g < NUM_OUT) begin : g_on
      if_axi_stream #(.DAT_BITS(DAT_BITS), .CTL_BITS(CTL_BITS), .MOD_BITS(MOD_BITS)) w_ch_in ();

      assign w_ch_in.val = w_route && (w_sel == LOG2_NUM_OUT'(g));
      assign w_ch_in.sop = i_axi.sop;
      assign w_ch_in.eop = i_axi.eop;
      assign w_ch_in.err = i_axi.err;
      assign w_ch_in.mod = i_axi.mod;
      assign w_ch_in.dat = i_axi.dat;
      assign w_ch_in.ctl = i_axi.ctl;
      assign w_ch_rdy[g] = w_ch_in.rdy;

      packet_demux_skid #(
        .DAT_BITS(DAT_BITS),
        .CTL_BITS(CTL_BITS),
        .MOD_BITS(MOD_BITS)
      ) u_skid (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_axi (w_ch_in),
        .o_axi (o_n_axi[g])
      );
    end else begin : g_pad
      assign w_ch_rdy[g] = 1'b1;
    end
  end

endmodule
